// File: rtl/stage_pkg.sv
// Shared definitions for pipeline stage 2: opcode constants, FSM encoding and
// the parity helper used by the single-error-detect logic.
package stage_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PARITY_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RETRY = 2'd1,
    ST_FATAL = 2'd2
  } state_t;

  // Even parity: the parity bit equals the XOR of the data bits, so the XOR
  // over data and parity together is zero for a clean word.
  function automatic logic even_parity_ok(input logic [PARITY_MAX_W-1:0] data,
                                          input logic                    p);
    return ~(^{data, p});
  endfunction

endpackage

// File: rtl/sed_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, and is
// cleared synchronously by clear_i.
module sed_sat_counter #(
  parameter int count_w = 16
) (
  input  logic               clk,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [count_w-1:0] count_o
);

  logic [count_w-1:0] count_q;

  // Count up unless already saturated; clear takes priority.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {count_w{1'b1}})) begin
      count_q <= count_q + count_w'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stage_2_sed.sv
// Pipeline stage 2: even-parity check on every non-NOP word, one-cycle
// forwarding of clean words, upstream replay requests with a bounded retry
// budget and a sticky fatal flag once that budget is spent.
//
// Handshake: there is no backpressure. A word is accepted every cycle;
// valid_out=1 marks a clean non-NOP word on the registered outputs, and
// retry_req is a single-cycle request for upstream to replay its last word.
module stage_2_sed
  import stage_pkg::*;
#(
  parameter int data_size     = 32,
  parameter int tag_size      = 8,
  parameter int max_retry     = 3,
  parameter int retry_timeout = 16,
  parameter int count_w       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    opcode_in,
  input  logic [data_size-1:0]          data_in,
  input  logic                          parity_in,
  input  logic [data_size+tag_size-1:0] ndt_in,
  output logic [1:0]                    opcode_out,
  output logic [data_size-1:0]          data_out,
  output logic [data_size+tag_size-1:0] ndt_out,
  output logic                          valid_out,
  output logic                          retry_req,
  output logic                          stall,
  output logic                          err_fatal,
  output logic [count_w-1:0]            err_count,
  output logic [1:0]                    state_dbg
);

  localparam int RW = $clog2(max_retry + 1);
  localparam int TW = $clog2(retry_timeout);
  localparam logic [RW-1:0] MAX_RETRY_L = RW'(max_retry);
  localparam logic [TW-1:0] TIMEOUT_L   = TW'(retry_timeout - 1);

  state_t                          state_q, state_d;
  logic [RW-1:0]                   retry_cnt_q, retry_cnt_d;
  logic [TW-1:0]                   timer_q, timer_d;
  logic                            pass_d;
  logic                            retry_d;
  logic                            is_op;
  logic                            perr;

  logic [1:0]                      opcode_q;
  logic [data_size-1:0]            data_q;
  logic [data_size+tag_size-1:0]   ndt_q;
  logic                            valid_q;
  logic                            retry_q;
  logic                            stall_q;
  logic                            fatal_q;

  assign is_op = (opcode_in != OP_NOP);
  assign perr  = is_op && !even_parity_ok(PARITY_MAX_W'(data_in), parity_in);

  // Next-state logic: decide pass/drop, replay requests and retry bookkeeping.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    timer_d     = timer_q;
    pass_d      = 1'b0;
    retry_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (is_op) begin
          if (perr) begin
            retry_d     = 1'b1;
            retry_cnt_d = RW'(1);
            timer_d     = '0;
            state_d     = ST_RETRY;
          end else begin
            pass_d = 1'b1;
          end
        end
      end
      ST_RETRY: begin
        if (!is_op) begin
          if (timer_q == TIMEOUT_L) begin
            // A timed-out wait spends one attempt, just like a bad replay.
            if (retry_cnt_q < MAX_RETRY_L) begin
              retry_d     = 1'b1;
              retry_cnt_d = retry_cnt_q + RW'(1);
              timer_d     = '0;
            end else begin
              state_d = ST_FATAL;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else if (!perr) begin
          pass_d      = 1'b1;
          retry_cnt_d = '0;
          timer_d     = '0;
          state_d     = ST_RUN;
        end else if (retry_cnt_q < MAX_RETRY_L) begin
          retry_d     = 1'b1;
          retry_cnt_d = retry_cnt_q + RW'(1);
          timer_d     = '0;
        end else begin
          state_d = ST_FATAL;
        end
      end
      ST_FATAL: begin
        state_d = ST_FATAL;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, bookkeeping and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      retry_cnt_q <= '0;
      timer_q     <= '0;
      opcode_q    <= OP_NOP;
      data_q      <= '0;
      ndt_q       <= '0;
      valid_q     <= 1'b0;
      retry_q     <= 1'b0;
      stall_q     <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      timer_q     <= timer_d;
      opcode_q    <= pass_d ? opcode_in : OP_NOP;
      data_q      <= data_in;
      ndt_q       <= ndt_in;
      valid_q     <= pass_d;
      retry_q     <= retry_d;
      stall_q     <= (state_d != ST_RUN);
      fatal_q     <= fatal_q | (state_d == ST_FATAL);
    end
  end

  sed_sat_counter #(
    .count_w (count_w)
  ) u_err_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (perr),
    .count_o (err_count)
  );

  assign opcode_out = opcode_q;
  assign data_out   = data_q;
  assign ndt_out    = ndt_q;
  assign valid_out  = valid_q;
  assign retry_req  = retry_q;
  assign stall      = stall_q;
  assign err_fatal  = fatal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_stage_2_sed.sv
// Directed bench for stage_2_sed: clean forwarding, replay, retry exhaustion,
// timeout re-requests, reset recovery and error-counter saturation.
module tb_stage_2_sed;

  localparam int DS = 32;
  localparam int TS = 8;

  logic          clk;
  logic          reset;
  logic [1:0]    opcode_in;
  logic [DS-1:0] data_in;
  logic          parity_in;
  logic [DS+TS-1:0] ndt_in;

  logic [1:0]    opcode_out, opcode_out_s;
  logic [DS-1:0] data_out, data_out_s;
  logic [DS+TS-1:0] ndt_out, ndt_out_s;
  logic          valid_out, valid_out_s;
  logic          retry_req, retry_req_s;
  logic          stall, stall_s;
  logic          err_fatal, err_fatal_s;
  logic [15:0]   err_count;
  logic [3:0]    err_count_s;
  logic [1:0]    state_dbg, state_dbg_s;

  int checks;
  int errors;

  stage_2_sed #(
    .data_size(DS), .tag_size(TS), .max_retry(3), .retry_timeout(16), .count_w(16)
  ) dut (
    .clk(clk), .reset(reset), .opcode_in(opcode_in), .data_in(data_in),
    .parity_in(parity_in), .ndt_in(ndt_in), .opcode_out(opcode_out),
    .data_out(data_out), .ndt_out(ndt_out), .valid_out(valid_out),
    .retry_req(retry_req), .stall(stall), .err_fatal(err_fatal),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  stage_2_sed #(
    .data_size(DS), .tag_size(TS), .max_retry(3), .retry_timeout(16), .count_w(4)
  ) dut_sat (
    .clk(clk), .reset(reset), .opcode_in(opcode_in), .data_in(data_in),
    .parity_in(parity_in), .ndt_in(ndt_in), .opcode_out(opcode_out_s),
    .data_out(data_out_s), .ndt_out(ndt_out_s), .valid_out(valid_out_s),
    .retry_req(retry_req_s), .stall(stall_s), .err_fatal(err_fatal_s),
    .err_count(err_count_s), .state_dbg(state_dbg_s)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word, then sample its registered result just after the edge.
  task automatic step(input logic [1:0] op, input logic [DS-1:0] d, input logic p);
    opcode_in = op;
    data_in   = d;
    parity_in = p;
    ndt_in    = {8'hA5, d};
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(2'b00, '0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [1:0] op, input logic v,
                           input logic r, input logic s, input logic f,
                           input logic [15:0] cnt);
    check({tag, ".opcode"}, 64'(opcode_out), 64'(op));
    check({tag, ".valid"},  64'(valid_out),  64'(v));
    check({tag, ".retry"},  64'(retry_req),  64'(r));
    check({tag, ".stall"},  64'(stall),      64'(s));
    check({tag, ".fatal"},  64'(err_fatal),  64'(f));
    check({tag, ".count"},  64'(err_count),  64'(cnt));
  endtask

  int pulses;
  int p1, p2, fatal_at;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    opcode_in = 2'b00;
    data_in   = '0;
    parity_in = 1'b0;
    ndt_in    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out("reset", 2'b00, 0, 0, 0, 0, 16'd0);
    check("reset.data",  64'(data_out), 64'd0);
    check("reset.ndt",   64'(ndt_out),  64'd0);
    check("reset.state", 64'(state_dbg), 64'd0);
    reset = 1'b0;

    // 1: clean stream
    step(2'b01, 32'h0000_0003, 1'b0);
    check_out("clean1", 2'b01, 1, 0, 0, 0, 16'd0);
    check("clean1.data", 64'(data_out), 64'h3);
    check("clean1.ndt",  64'(ndt_out),  64'hA5_0000_0003);
    step(2'b10, 32'h8000_0000, 1'b1);
    check_out("clean2", 2'b10, 1, 0, 0, 0, 16'd0);
    check("clean2.data", 64'(data_out), 64'h8000_0000);
    step(2'b00, 32'h0, 1'b0);
    check_out("nop", 2'b00, 0, 0, 0, 0, 16'd0);

    // 2: single error, good replay
    step(2'b01, 32'h1, 1'b0);
    check_out("err1", 2'b00, 0, 1, 1, 0, 16'd1);
    check("err1.data_loaded", 64'(data_out), 64'h1);
    check("err1.state", 64'(state_dbg), 64'd1);
    step(2'b00, 32'h0, 1'b0);
    check_out("err1.wait", 2'b00, 0, 0, 1, 0, 16'd1);
    step(2'b01, 32'h1, 1'b1);
    check_out("replay", 2'b01, 1, 0, 0, 0, 16'd1);
    check("replay.state", 64'(state_dbg), 64'd0);

    // 3: exhaust retries (bad word + 3 bad replays, NOP between)
    pulse_reset();
    pulses = 0;
    step(2'b01, 32'h1, 1'b0);
    if (retry_req) pulses++;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 32'h0, 1'b0);
      if (retry_req) pulses++;
      step(2'b11, 32'h7, 1'b0);
      if (retry_req) pulses++;
    end
    check("exhaust.pulses", 64'(pulses), 64'd3);
    check_out("exhaust", 2'b00, 0, 0, 1, 1, 16'd4);
    check("exhaust.state", 64'(state_dbg), 64'd2);
    step(2'b01, 32'h3, 1'b0);
    check_out("fatal.drop", 2'b00, 0, 0, 1, 1, 16'd4);

    // 5a: reset while in FATAL
    pulse_reset();
    check_out("rst_fatal", 2'b00, 0, 0, 0, 0, 16'd0);
    check("rst_fatal.state", 64'(state_dbg), 64'd0);
    step(2'b10, 32'h0000_00F0, 1'b0);
    check_out("rst_fatal.pass", 2'b10, 1, 0, 0, 0, 16'd0);

    // 4: timeout re-requests
    step(2'b01, 32'h1, 1'b0);
    check("tmo.first_pulse", 64'(retry_req), 64'd1);
    pulses   = 0;
    p1       = 0;
    p2       = 0;
    fatal_at = 0;
    for (int k = 1; k <= 60; k++) begin
      step(2'b00, 32'h0, 1'b0);
      if (retry_req) begin
        pulses++;
        if (pulses == 1) p1 = k;
        else if (pulses == 2) p2 = k;
      end
      if (state_dbg == 2'd2 && fatal_at == 0) fatal_at = k;
      if (fatal_at != 0) break;
    end
    check("tmo.pulses",   64'(pulses),   64'd2);
    check("tmo.p1",       64'(p1),       64'd16);
    check("tmo.p2",       64'(p2),       64'd32);
    check("tmo.fatal_at", 64'(fatal_at), 64'd48);
    check_out("tmo.fatal", 2'b00, 0, 0, 1, 1, 16'd1);

    // 5b: reset mid-RETRY
    pulse_reset();
    step(2'b01, 32'h1, 1'b0);
    step(2'b00, 32'h0, 1'b0);
    check("mid.state", 64'(state_dbg), 64'd1);
    pulse_reset();
    check_out("rst_retry", 2'b00, 0, 0, 0, 0, 16'd0);
    check("rst_retry.state", 64'(state_dbg), 64'd0);
    step(2'b11, 32'h5, 1'b0);
    check_out("rst_retry.pass", 2'b11, 1, 0, 0, 0, 16'd0);

    // 6: saturation on a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 32'h1, 1'b0);
      step(2'b00, 32'h0, 1'b0);
    end
    check("sat.count4", 64'(err_count_s), 64'hF);
    check("sat.count16", 64'(err_count), 64'd20);
    check("sat.fatal", 64'(err_fatal_s), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
